// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// The break code is also consumed by the downstream scan-code mapper.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Bundle between the PS/2 connector side and the scan-code consumer.
// got_code and frame_err are valid-only strobes with no ready: each is high for exactly one
// clk, never together, and scan_code is valid with got_code and holds until the next good frame.
interface ps2_frame_receiver_if;
  import ps2_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       got_code;
  logic       frame_err;
  state_t     state;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scan_code,
    input  got_code,
    input  frame_err,
    input  state
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scan_code,
    output got_code,
    output frame_err,
    output state
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Brings the raw PS/2 pins into the clk domain: both pins get a 2-flop synchroniser, the
// clock additionally gets a saturating glitch filter and a one-cycle falling-edge pulse.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_clk,
  input  logic raw_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync_q;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_q;

  // The counter only advances while the synced clock disagrees with the filtered level,
  // so any run of opposite samples shorter than FILTER_LEN is forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync    <= 2'b11;
      data_sync_q <= 2'b11;
      cnt         <= '0;
      level       <= 1'b1;
      level_q     <= 1'b1;
    end else begin
      clk_sync    <= {clk_sync[0], raw_clk};
      data_sync_q <= {data_sync_q[0], raw_data};
      level_q     <= level;
      if (clk_sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= clk_sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign data_sync = data_sync_q[1];
  assign fall      = level_q & ~level;

endmodule

// File: rtl/ps2_frame_receiver.sv
// Deserialises 11-bit PS/2 device-to-host frames into scan codes, dropping malformed or
// stalled frames with a frame_err strobe.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_frame_receiver_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(PS2_DATA_BITS + 1);

  logic data_sync;
  logic fall;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_clk   (bus.ps2_clk),
    .raw_data  (bus.ps2_data),
    .data_sync (data_sync),
    .fall      (fall)
  );

  state_t                   state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic [TW-1:0]            to_cnt_q, to_cnt_d;
  logic [7:0]               code_q, code_d;
  logic                     got_q, got_d;
  logic                     err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      code_q    <= 8'h00;
      got_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      code_q    <= code_d;
      got_q     <= got_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    code_d    = code_q;
    got_d     = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = (state_q == IDLE || fall) ? '0 : to_cnt_q + TW'(1);

    // Expiry takes priority: a fall landing in the expiry cycle belongs to no frame.
    if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
      err_d     = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_sync) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {data_sync, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_sync;
          state_d  = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (data_sync && odd_parity_ok(shift_q, parity_q)) begin
            code_d = shift_q;
            got_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.scan_code = code_q;
  assign bus.got_code  = got_q;
  assign bus.frame_err = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Drives PS/2 frames (directed and random) into ps2_frame_receiver and checks every
// got_code/frame_err strobe, its cycle and scan_code against a frame-level model.
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HP             = 24;                 // PS/2 half period in clk cycles
  localparam int LAT            = 2 + FILTER_LEN + 1; // raw pin edge -> strobe visible
  localparam int EW             = 42;                 // {cycle[31:0], kind[1:0], code[7:0]}

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_frame_receiver_if bus();

  ps2_frame_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [7:0]    last_code = 8'h00;
  int            n_checks  = 0;
  int            n_fail    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.got_code || bus.frame_err)) begin
      check("strobe_exclusive", 64'(bus.got_code & bus.frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'({bus.frame_err, bus.got_code}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 64'({bus.frame_err, bus.got_code}), 64'(e[9:8]));
        check("strobe_cycle", 64'(cyc), 64'(e[41:10]));
        check("scan_code", 64'(bus.scan_code), 64'(e[7:0]));
      end
    end
  end

  // drivers
  task automatic ps2_bit(input logic b, input logic glitch, input logic has_ev,
                         input logic [9:0] ev, input int extra);
    @(negedge clk);
    bus.ps2_data = b;
    repeat (12) @(negedge clk);
    if (glitch) bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (HP - 15) @(negedge clk);
    bus.ps2_clk = 1'b0;
    if (has_ev) exp_q.push_back({32'(cyc + LAT + extra), ev});
    repeat (HP) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic glitch);
    logic [PS2_FRAME_BITS-1:0] bits;
    logic [9:0]                ev;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (!bad_par && !bad_stop) begin
      ev        = {2'b01, b};
      last_code = b;
    end else begin
      ev = {2'b10, last_code};
    end
    for (int i = 0; i < PS2_FRAME_BITS; i++)
      ps2_bit(bits[i], glitch, i == PS2_FRAME_BITS - 1, ev, 0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n, input logic expect_timeout);
    ps2_bit(1'b0, 1'b0, 1'b0, 10'd0, 0);
    for (int i = 0; i < n; i++)
      ps2_bit(b[i], 1'b0, expect_timeout && (i == n - 1), {2'b10, last_code}, TIMEOUT_CYCLES);
  endtask

  task automatic glitch_idle();
    @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_scan_code"}, 64'(bus.scan_code), 64'h00);
    check({tag, "_got_code"}, 64'(bus.got_code), 64'd0);
    check({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
    check({tag, "_state"}, 64'(bus.state), 64'(IDLE));
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    int         kind;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);              // bad parity, scan_code stays 00
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(PS2_BREAK_CODE, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("hold_after_pair", 64'(bus.scan_code), 64'h1C);

    ps2_bit(1'b1, 1'b0, 1'b1, {2'b10, last_code}, 0); // start bit of 1
    send_frame(8'h3B, 1'b0, 1'b1, 1'b0);              // bad stop bit

    send_partial(8'h29, 5, 1'b1);
    repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);

    glitch_idle();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    glitch_idle();
    repeat (20) @(negedge clk);
    check("hold_after_glitch", 64'(bus.scan_code), 64'h5A);

    send_partial(8'hA5, 4, 1'b0);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    last_code    = 8'h00;
    #1;
    check_reset_values("mid_frame_reset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("pending_after_reset", 64'(exp_q.size()), 64'd0);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      rb   = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      send_frame(rb, kind == 0, kind == 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    repeat (100) @(negedge clk);
    check("final_scan_code", 64'(bus.scan_code), 64'(last_code));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Upstream stage of the Hack keyboard path. Receives raw PS/2 clock/data from the keyboard connector and deserialises 11-bit device-to-host frames. Outputs one validated scan code byte per frame with a single-cycle strobe that feeds the scan-code-to-Hack-keycode mapper (scan_code / got_code). Rejects malformed frames and recovers from stalled transfers.

Parameters:
FILTER_LEN, 8, consecutive identical clk samples required before the filtered PS/2 clock changes level (glitch reject)
TIMEOUT_CYCLES, 50000, clk cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk
ps2_data  in  1  raw PS/2 data pin, asynchronous to clk
scan_code  out  8  last correctly received byte
got_code  out  1  one-cycle strobe: scan_code holds a new byte
frame_err  out  1  one-cycle strobe: frame dropped (start/parity/stop/timeout)

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), clock is clk.
- Reset values: scan_code=8'h00, got_code=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0, filtered clock=1, synchronisers=1.
- Input conditioning: ps2_clk and ps2_data each pass a 2-flop synchroniser. Synced ps2_clk feeds a saturating counter filter: filtered level changes only after FILTER_LEN consecutive samples of the opposite level. A pulse shorter than FILTER_LEN cycles has no effect.
- fall = registered filtered clock was 1 and is now 0; exactly one-cycle pulse per PS/2 falling edge. Data is sampled from synced ps2_data in the fall cycle.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM states and transitions:
  - IDLE: on fall, if data=0 -> DATA with bit count=0. If data=1 -> pulse frame_err and stay in IDLE.
  - DATA: on fall, shift the bit into the shift register MSB end (right shift), increment the count. After the 8th bit -> PARITY.
  - PARITY: on fall, store the parity bit -> STOP.
  - STOP: on fall, if data=1 and the XOR of 8 data bits and parity bit =1 -> latch scan_code and pulse got_code. Otherwise pulse frame_err and leave scan_code unchanged. Either way -> IDLE.
- Latency: got_code/frame_err assert in the cycle after the stop-bit fall cycle, for exactly one cycle. scan_code updates in the same cycle and holds until the next good frame.
- got_code and frame_err are never asserted together.
- Timeout:
  - The counter resets on every fall and counts while state != IDLE.
  - Reaching TIMEOUT_CYCLES-1 -> pulse frame_err, go to IDLE, clear bit count. A fall in that same cycle is ignored.
  - The counter does not run in IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES); it must not wrap before expiry.
- Reset mid-frame: everything returns to reset values immediately, and the partial frame is discarded. The first fall after reset release is treated as a start bit.
- Host-to-device transmission is not supported; ps2 pins are input-only.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, DATA, PARITY, STOP), 2 bits
  - PS2_DATA_BITS=8
  - PS2_FRAME_BITS=11
  - PS2_BREAK_CODE=8'hF0, shared with the downstream mapper
- Sub-module ps2_sync_filter: 2-flop synchroniser plus saturating glitch filter plus fall detect. Parameter FILTER_LEN; outputs filtered data level and fall pulse. Instantiated once for the clock path; the data path reuses only its synchroniser portion.

Test Plan:
- Send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 40 us PS/2 period -> exactly one got_code pulse, scan_code=8'h1C, frame_err never asserted.
- Send 0xF0 (parity 1) then 0x1C back-to-back -> two got_code pulses. scan_code=8'hF0 after the first pulse and 8'h1C after the second.
- Send 0x1C with parity bit 1 -> frame_err one pulse, no got_code, scan_code keeps its previous value (8'h00 after reset).
- Send start plus 5 data bits, then hold ps2_clk high -> frame_err pulse exactly TIMEOUT_CYCLES cycles after the last fall. A subsequent full 0x29 frame -> got_code, scan_code=8'h29.
- Inject 3-cycle low glitches on ps2_clk (FILTER_LEN=8) between and during frames of 0x5A -> no extra bits, scan_code=8'h5A, no frame_err.
- Assert rst_n low after 4 data bits of a frame, release, send 0x66 -> outputs at reset values during reset, then a single got_code with scan_code=8'h66.
